// File: rtl/inst_decoder_pipe_pkg.sv
// Shared types for the RV32I/RV64I decode stage.
// Decoded record, opcode classes and immediate helpers.
package inst_decoder_pipe_pkg;

  localparam int cXlenDefault = 32;
  localparam int cXlenMax = 64;
  localparam int cPcWMax = 64;
  localparam int cRegSelBitW = 5;

  typedef logic [cXlenMax-1:0] tXword;

  typedef enum logic [6:0] {
    eOpIllegal = 7'b0000000,
    eOpLoad    = 7'b0000011,
    eOpFence   = 7'b0001111,
    eOpImm     = 7'b0010011,
    eOpAuIpc   = 7'b0010111,
    eOpStore   = 7'b0100011,
    eOpRType   = 7'b0110011,
    eOpLui     = 7'b0110111,
    eOpBranch  = 7'b1100011,
    eOpJalr    = 7'b1100111,
    eOpJal     = 7'b1101111,
    eOpCntrlSt = 7'b1110011
  } tOpClass;

  typedef struct packed {
    logic [cRegSelBitW-1:0] addr;
    logic dv;
  } tRegSel;

  typedef struct packed {
    logic [2:0] val;
    logic dv;
  } tFunct3;

  typedef struct packed {
    logic [6:0] val;
    logic dv;
  } tFunct7;

  typedef struct packed {
    tXword value;
    logic dv;
  } tImm;

  typedef struct packed {
    tRegSel rs1;
    tRegSel rs2;
    tRegSel rd;
    tFunct3 funct3;
    tFunct7 funct7;
    tImm imm;
    tOpClass opClass;
    logic illegal;
    logic [cPcWMax-1:0] pc;
  } tDecodedInstX;

  localparam logic [2:0] cF3Add = 3'b000;
  localparam logic [2:0] cF3Sll = 3'b001;
  localparam logic [2:0] cF3Lw  = 3'b010;
  localparam logic [2:0] cF3Srl = 3'b101;

  // Bits above the configured width stay zero on RV32.
  function automatic tXword sext32(input logic [31:0] v, input int xlen);
    return (xlen == 64) ? {{32{v[31]}}, v} : {32'b0, v};
  endfunction

endpackage

// File: rtl/inst_decoder_pipe_if.sv
// Fetch-side and register-read-side handshakes of the decoder.
// master = producer/consumer environment, slave = decoder.
interface inst_decoder_pipe_if
  import inst_decoder_pipe_pkg::*;
#(
  parameter int cPcW = 32
) ();
  logic valid;
  logic ready;
  logic [31:0] inst;
  logic [cPcW-1:0] pc;
  logic dec_valid;
  logic dec_ready;
  tDecodedInstX decoded;

  modport master (
    output valid, inst, pc, dec_ready,
    input ready, dec_valid, decoded
  );

  modport slave (
    input valid, inst, pc, dec_ready,
    output ready, dec_valid, decoded
  );
endinterface

// File: rtl/inst_decode_comb.sv
// Combinational instruction word to decoded record.
// Illegal words keep only pc and the illegal flag.
module inst_decode_comb
  import inst_decoder_pipe_pkg::*;
#(
  parameter int cXlen = cXlenDefault,
  parameter int cPcW = 32,
  parameter int cIllegalChk = 1
) (
  input  logic [31:0]     inst,
  input  logic [cPcW-1:0] pc,
  output tDecodedInstX    decoded
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] imm32;
  logic known;
  logic bad;
  logic shift;
  logic illegal;

  assign opc = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign shift = (opc == eOpImm) && (f3 == cF3Sll || f3 == cF3Srl);
  assign illegal = (inst[1:0] != 2'b11) || !known || bad;

  always_comb begin
    imm32 = '0;
    known = 1'b1;
    unique case (opc)
      eOpLoad, eOpImm, eOpJalr:
        imm32 = {{20{inst[31]}}, inst[31:20]};
      eOpStore:
        imm32 = {{20{inst[31]}}, f7, inst[11:7]};
      eOpBranch:
        imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      eOpLui, eOpAuIpc:
        imm32 = {inst[31:12], 12'b0};
      eOpJal:
        imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      eOpRType, eOpFence, eOpCntrlSt:
        imm32 = '0;
      default:
        known = 1'b0;
    endcase
  end

  // RV64 shifts take a 6-bit shamt, so only funct7[6:1] is checked.
  always_comb begin
    bad = 1'b0;
    if (cIllegalChk != 0) begin
      unique case (1'b1)
        opc == eOpLoad:
          bad = (f3 == 3'b111) ||
                (cXlen == 32 && (f3 == 3'b011 || f3 == 3'b110));
        opc == eOpStore:
          bad = f3 >= ((cXlen == 64) ? 3'b100 : 3'b011);
        opc == eOpBranch:
          bad = (f3 == 3'b010) || (f3 == 3'b011);
        opc == eOpJalr:
          bad = f3 != 3'b000;
        opc == eOpRType:
          bad = !(f7 == 7'b0 ||
                  (f7 == 7'b0100000 && (f3 == cF3Add || f3 == cF3Srl)));
        shift:
          bad = (cXlen == 64) ?
                !(f7[6:1] == 6'b0 ||
                  (f3 == cF3Srl && f7[6:1] == 6'b010000)) :
                !(f7 == 7'b0 ||
                  (f3 == cF3Srl && f7 == 7'b0100000));
        default:
          bad = 1'b0;
      endcase
    end
  end

  always_comb begin
    decoded = '0;
    decoded.pc[cPcW-1:0] = pc;
    decoded.illegal = illegal;
    if (!illegal) begin
      decoded.opClass = tOpClass'(opc);
      decoded.rs1.addr = inst[19:15];
      decoded.rs2.addr = inst[24:20];
      decoded.rd.addr = inst[11:7];
      decoded.funct3.val = f3;
      decoded.funct7.val = f7;
      decoded.rs1.dv = opc inside {eOpLoad, eOpImm, eOpStore,
                                   eOpRType, eOpBranch, eOpJalr};
      decoded.rs2.dv = opc inside {eOpStore, eOpRType, eOpBranch};
      decoded.rd.dv = (inst[11:7] != 5'd0) &&
                      (opc inside {eOpLoad, eOpImm, eOpAuIpc, eOpRType,
                                   eOpLui, eOpJalr, eOpJal});
      decoded.funct3.dv = !(opc inside {eOpLui, eOpAuIpc, eOpJal});
      decoded.funct7.dv = (opc == eOpRType) || shift;
      decoded.imm.dv = !(opc inside {eOpRType, eOpFence, eOpCntrlSt});
      decoded.imm.value = sext32(imm32, cXlen);
    end
  end

endmodule

// File: rtl/inst_decoder_pipe.sv
// Decode stage with a 2-entry skid buffer and flush.
// r0 drives the outputs, r1 absorbs one word of backpressure.
module inst_decoder_pipe
  import inst_decoder_pipe_pkg::*;
#(
  parameter int cXlen = cXlenDefault,
  parameter int cPcW = 32,
  parameter int cIllegalChk = 1
) (
  input logic iClk,
  input logic iRst,
  input logic iFlush,
  inst_decoder_pipe_if.slave bus
);
  typedef enum logic [1:0] {
    eEmpty,
    eOne,
    eFull
  } tOcc;

  tOcc state;
  tDecodedInstX r0;
  tDecodedInstX r1;
  tDecodedInstX dec;
  logic live;
  logic accept;
  logic drain;

  inst_decode_comb #(
    .cXlen(cXlen),
    .cPcW(cPcW),
    .cIllegalChk(cIllegalChk)
  ) u_dec (
    .inst(bus.inst),
    .pc(bus.pc),
    .decoded(dec)
  );

  // live holds ready low until the first edge after reset release.
  assign bus.ready = live && (state != eFull);
  assign bus.dec_valid = state != eEmpty;
  assign bus.decoded = r0;
  assign accept = bus.valid && bus.ready;
  assign drain = bus.dec_valid && bus.dec_ready;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state <= eEmpty;
      r0 <= '0;
      r1 <= '0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      if (iFlush) begin
        state <= eEmpty;
      end else begin
        unique case (state)
          eEmpty: begin
            if (accept) begin
              r0 <= dec;
              state <= eOne;
            end
          end
          eOne: begin
            if (accept && drain) begin
              r0 <= dec;
            end else if (accept) begin
              r1 <= dec;
              state <= eFull;
            end else if (drain) begin
              state <= eEmpty;
            end
          end
          eFull: begin
            if (drain) begin
              r0 <= r1;
              state <= eOne;
            end
          end
          default: state <= eEmpty;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_decoder_pipe.sv
// Randomised and directed checks of inst_decoder_pipe.
// Expected records come from a table-driven decode model.
module tb_inst_decoder_pipe;
  import inst_decoder_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int total = 0;
  int bad = 0;

  localparam logic [6:0] OPS [11] = '{
    7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
    7'h37, 7'h63, 7'h67, 7'h6F, 7'h73
  };

  inst_decoder_pipe_if #(.cPcW(32)) bus ();
  inst_decoder_pipe_if #(.cPcW(32)) bus64 ();

  inst_decoder_pipe #(
    .cXlen(32), .cPcW(32), .cIllegalChk(1)
  ) u_dut (
    .iClk(clk), .iRst(rst_n), .iFlush(flush), .bus(bus)
  );

  inst_decoder_pipe #(
    .cXlen(64), .cPcW(32), .cIllegalChk(1)
  ) u_dut64 (
    .iClk(clk), .iRst(rst_n), .iFlush(flush), .bus(bus64)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Table of per-opcode properties; immediates via signed arithmetic.
  function automatic tDecodedInstX model(input logic [31:0] w,
                                         input logic [31:0] pc,
                                         input int xlen);
    tDecodedInstX d;
    int f3, f7, hi6;
    byte kind;
    bit r1, r2, rd, f7v, ok;
    longint imm;
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    hi6 = int'(w[31:26]);
    d = '0;
    d.pc = {32'b0, pc};
    ok = 1'b1;
    kind = "-";
    r1 = 1'b0;
    r2 = 1'b0;
    rd = 1'b0;
    f7v = 1'b0;
    case (w[6:0])
      7'h03: begin
        kind = "I"; r1 = 1; rd = 1;
        ok = (xlen == 64) ? f3 != 7 :
             (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      7'h0F: ok = 1'b1;
      7'h13: begin
        kind = "I"; r1 = 1; rd = 1;
        if (f3 == 1) begin
          f7v = 1;
          ok = (xlen == 64) ? hi6 == 0 : f7 == 0;
        end
        if (f3 == 5) begin
          f7v = 1;
          ok = (xlen == 64) ? (hi6 == 0 || hi6 == 16) :
                              (f7 == 0 || f7 == 32);
        end
      end
      7'h17: begin kind = "U"; rd = 1; end
      7'h23: begin
        kind = "S"; r1 = 1; r2 = 1;
        ok = f3 < ((xlen == 64) ? 4 : 3);
      end
      7'h33: begin
        r1 = 1; r2 = 1; rd = 1; f7v = 1;
        ok = f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5));
      end
      7'h37: begin kind = "U"; rd = 1; end
      7'h63: begin
        kind = "B"; r1 = 1; r2 = 1;
        ok = f3 != 2 && f3 != 3;
      end
      7'h67: begin kind = "I"; r1 = 1; rd = 1; ok = f3 == 0; end
      7'h6F: begin kind = "J"; rd = 1; end
      7'h73: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d.illegal = 1'b1;
      return d;
    end
    case (kind)
      "I": imm = longint'($signed(w[31:20]));
      "S": imm = longint'($signed({w[31:25], w[11:7]}));
      "B": imm = longint'($signed({w[31], w[7], w[30:25],
                                   w[11:8], 1'b0}));
      "U": imm = longint'($signed({w[31:12], 12'h000}));
      "J": imm = longint'($signed({w[31], w[19:12], w[20],
                                   w[30:21], 1'b0}));
      default: imm = 0;
    endcase
    d.opClass = tOpClass'(w[6:0]);
    d.rs1.addr = w[19:15];
    d.rs1.dv = r1;
    d.rs2.addr = w[24:20];
    d.rs2.dv = r2;
    d.rd.addr = w[11:7];
    d.rd.dv = rd && (w[11:7] != 5'd0);
    d.funct3.val = w[14:12];
    d.funct3.dv = !(w[6:0] inside {7'h17, 7'h37, 7'h6F});
    d.funct7.val = w[31:25];
    d.funct7.dv = f7v;
    d.imm.dv = kind != "-";
    d.imm.value = (xlen == 64) ? tXword'(imm) :
                  tXword'(imm) & 64'h0000_0000_FFFF_FFFF;
    return d;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) != 0)
      w[6:0] = OPS[$urandom_range(0, 10)];
    if ($urandom_range(0, 1) != 0)
      w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic test_reset();
    total++;
    if (bus.dec_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%0b exp=0", bus.dec_valid);
    end
    total++;
    if (bus.ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_ready got=%0b exp=0", bus.ready);
    end
    total++;
    if (bus.decoded !== '0) begin
      bad++;
      $display("FAIL rst_decoded got=%h exp=0", bus.decoded);
    end
    #1 rst_n = 1'b1;
    #1;
    total++;
    if (bus.ready !== 1'b0) begin
      bad++;
      $display("FAIL rel_ready_early got=%0b exp=0", bus.ready);
    end
    cyc();
    total++;
    if (bus.ready !== 1'b1 || bus.dec_valid !== 1'b0) begin
      bad++;
      $display("FAIL rel_ready got=%0b/%0b exp=1/0",
               bus.ready, bus.dec_valid);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] w [9] = '{
      32'hFFC12283, 32'hFE208CE3, 32'h00000000,
      32'h00001067, 32'h021080B3, 32'h00000013,
      32'h00013083, 32'h800000B7, 32'h4200D093
    };
    tDecodedInstX d;
    logic [31:0] pc;
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      bus.inst = w[i];
      bus.pc = pc;
      bus.valid = 1'b1;
      cyc();
      d = bus.decoded;
      total++;
      if (bus.dec_valid !== 1'b1) begin
        bad++;
        $display("FAIL vec%0d_valid got=%0b exp=1", i, bus.dec_valid);
      end
      total++;
      if (d !== model(w[i], pc, 32)) begin
        bad++;
        $display("FAIL vec%0d_rec got=%h exp=%h",
                 i, d, model(w[i], pc, 32));
      end
      total++;
      case (i)
        0: if ({d.rs1.addr, d.rs1.dv, d.rd.addr, d.rd.dv,
                d.funct3.val, d.illegal, d.imm.value} !==
               {5'd2, 1'b1, 5'd5, 1'b1, 3'b010, 1'b0,
                64'h0000_0000_FFFF_FFFC}) begin
          bad++;
          $display("FAIL lw_fields got=%h", d);
        end
        1: if ({d.rs1.addr, d.rs2.addr, d.rd.dv, d.imm.value} !==
               {5'd1, 5'd2, 1'b0, 64'h0000_0000_FFFF_FFF8}) begin
          bad++;
          $display("FAIL beq_fields got=%h", d);
        end
        2, 3, 4: if ({d.illegal, d.rs1.dv, d.rs2.dv, d.rd.dv,
                      d.funct3.dv, d.funct7.dv, d.imm.dv, d.pc} !==
                     {7'b1000000, 32'b0, pc}) begin
          bad++;
          $display("FAIL illegal%0d got=%h exp_pc=%h", i, d, pc);
        end
        5: if ({d.rd.dv, d.illegal, d.rs1.dv} !== 3'b001) begin
          bad++;
          $display("FAIL addi_x0 got=%h", d);
        end
        6, 8: if (d.illegal !== 1'b1) begin
          bad++;
          $display("FAIL rv32_illegal%0d got=%0b exp=1", i, d.illegal);
        end
        default: if (d.imm.value !== 64'h0000_0000_8000_0000) begin
          bad++;
          $display("FAIL lui_imm got=%h exp=80000000", d.imm.value);
        end
      endcase
    end
    bus.valid = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3] = '{32'h00100093, 32'hFFF10113, 32'h00308193};
    tDecodedInstX got [$];
    tDecodedInstX ma;
    logic take;
    ma = model(w[0], 32'h2000, 32);
    bus.dec_ready = 1'b0;
    bus.valid = 1'b1;
    bus.inst = w[0];
    bus.pc = 32'h2000;
    cyc();
    bus.inst = w[1];
    bus.pc = 32'h2004;
    cyc();
    bus.inst = w[2];
    bus.pc = 32'h2008;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.ready !== 1'b0 || bus.decoded !== ma ||
          bus.dec_valid !== 1'b1) begin
        bad++;
        $display("FAIL hold%0d rdy=%0b vld=%0b got=%h exp=%h",
                 i, bus.ready, bus.dec_valid, bus.decoded, ma);
      end
      cyc();
    end
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.dec_valid) got.push_back(bus.decoded);
      take = bus.valid && bus.ready;
      cyc();
      if (take) bus.valid = 1'b0;
    end
    total++;
    if (got.size() != 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d exp=3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== model(w[i], 32'h2000 + 32'(4 * i), 32)) begin
        bad++;
        $display("FAIL b2b_order%0d got=%h", i, got[i]);
      end
    end
    bus.valid = 1'b0;
  endtask

  task automatic test_flush();
    bus.dec_ready = 1'b0;
    bus.valid = 1'b1;
    bus.inst = 32'h00100093;
    bus.pc = 32'h3000;
    cyc();
    bus.inst = 32'h00200113;
    cyc();
    total++;
    if (bus.ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_full got=%0b exp=0", bus.ready);
    end
    bus.inst = 32'h00300193;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    bus.valid = 1'b0;
    total++;
    if (bus.dec_valid !== 1'b0 || bus.ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_full_after vld=%0b rdy=%0b exp=0/1",
               bus.dec_valid, bus.ready);
    end
    bus.dec_ready = 1'b1;
    cyc();
    total++;
    if (bus.dec_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_drop got=%0b exp=0", bus.dec_valid);
    end
    bus.valid = 1'b1;
    bus.inst = 32'h00400213;
    cyc();
    bus.inst = 32'h00500293;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    bus.valid = 1'b0;
    total++;
    if (bus.dec_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_one got=%0b exp=0", bus.dec_valid);
    end
    cyc();
    total++;
    if (bus.dec_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_one_drop got=%0b exp=0", bus.dec_valid);
    end
  endtask

  task automatic test_random();
    tDecodedInstX q [$];
    tDecodedInstX e;
    for (int i = 0; i < 420; i++) begin
      bus.valid = (i < 400) && ($urandom_range(0, 9) < 7);
      bus.inst = gen_inst();
      bus.pc = $urandom;
      bus.dec_ready = (i >= 400) || ($urandom_range(0, 9) < 6);
      flush = (i < 400) && ($urandom_range(0, 49) == 0);
      total++;
      if (bus.dec_valid !== (q.size() != 0) ||
          bus.ready !== (q.size() < 2)) begin
        bad++;
        $display("FAIL rnd_occ%0d vld=%0b rdy=%0b held=%0d",
                 i, bus.dec_valid, bus.ready, q.size());
      end
      if (flush) begin
        q.delete();
      end else begin
        if (bus.dec_valid && bus.dec_ready && q.size() != 0) begin
          e = q.pop_front();
          total++;
          if (bus.decoded !== e) begin
            bad++;
            $display("FAIL rnd_rec%0d got=%h exp=%h",
                     i, bus.decoded, e);
          end
        end
        if (bus.valid && bus.ready)
          q.push_back(model(bus.inst, bus.pc, 32));
      end
      cyc();
    end
    flush = 1'b0;
    bus.valid = 1'b0;
    total++;
    if (q.size() != 0 || bus.dec_valid !== 1'b0) begin
      bad++;
      $display("FAIL rnd_drain held=%0d vld=%0b", q.size(), bus.dec_valid);
    end
  endtask

  task automatic test_async_reset();
    bus.dec_ready = 1'b0;
    bus.valid = 1'b1;
    bus.inst = 32'h00100093;
    bus.pc = 32'h4000;
    cyc();
    bus.valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (bus.dec_valid !== 1'b0 || bus.ready !== 1'b0 ||
        bus.decoded !== '0) begin
      bad++;
      $display("FAIL async_rst vld=%0b rdy=%0b rec=%h",
               bus.dec_valid, bus.ready, bus.decoded);
    end
    #2 rst_n = 1'b1;
    cyc();
    total++;
    if (bus.ready !== 1'b1) begin
      bad++;
      $display("FAIL async_rel got=%0b exp=1", bus.ready);
    end
    bus.valid = 1'b1;
    bus.inst = 32'h00000013;
    bus.pc = 32'h4100;
    bus.dec_ready = 1'b1;
    cyc();
    bus.valid = 1'b0;
    total++;
    if (bus.dec_valid !== 1'b1 || bus.decoded.rd.dv !== 1'b0 ||
        bus.decoded !== model(32'h00000013, 32'h4100, 32)) begin
      bad++;
      $display("FAIL async_first vld=%0b rec=%h",
               bus.dec_valid, bus.decoded);
    end
    cyc();
  endtask

  task automatic test_xlen64();
    logic [31:0] w [4] = '{
      32'hFE208CE3, 32'h00013083, 32'h800000B7, 32'h4200D093
    };
    logic [64:0] exp [4] = '{
      {1'b0, 64'hFFFF_FFFF_FFFF_FFF8},
      {1'b0, 64'h0000_0000_0000_0000},
      {1'b0, 64'hFFFF_FFFF_8000_0000},
      {1'b0, 64'h0000_0000_0000_0420}
    };
    tDecodedInstX d;
    bus64.dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus64.inst = w[i];
      bus64.pc = 32'h5000 + 32'(4 * i);
      bus64.valid = 1'b1;
      cyc();
      d = bus64.decoded;
      total++;
      if ({d.illegal, d.imm.value} !== exp[i] || bus64.dec_valid !== 1'b1) begin
        bad++;
        $display("FAIL x64_%0d got=%h exp=%h", i,
                 {d.illegal, d.imm.value}, exp[i]);
      end
      total++;
      if (d !== model(w[i], 32'h5000 + 32'(4 * i), 64)) begin
        bad++;
        $display("FAIL x64_rec%0d got=%h", i, d);
      end
    end
    bus64.valid = 1'b0;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.valid = 1'b0;
    bus.inst = '0;
    bus.pc = '0;
    bus.dec_ready = 1'b0;
    bus64.valid = 1'b0;
    bus64.inst = '0;
    bus64.pc = '0;
    bus64.dec_ready = 1'b1;
    #12;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    test_xlen64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
